bcd_ring_counter: RTL

- Parametrised N-digit BCD register bank for the DE-board display labs; each 4-bit digit drives one seven-segment display.
- Supports four modes: count up, count down, rotate left and rotate right. The rotate modes generalise the earlier fixed 4-stage digit ring.
- Adds synchronous parallel load, wrap/saturate selection and a carry/borrow pulse for cascading.
- Sits between the switch/key input logic and the HEX displays.

---
 rtl/display_pkg.sv | 25 ++
 rtl/bcd_ring_counter_if.sv | 30 +++
 rtl/seg7_decode.sv | 30 +++
 rtl/bcd_ring_counter.sv | 94 +++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the BCD ring counter and its seven-segment decoders.
// Holds the step-mode encodings and the active-low segment patterns
// (bit order a..g = bit0..bit6; a 0 lights the segment).
package display_pkg;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,  // decimal increment
    MODE_DN  = 2'b01,  // decimal decrement
    MODE_ROL = 2'b10,  // digit i moves to i+1, top digit wraps to 0
    MODE_ROR = 2'b11   // digit i+1 moves to i, digit 0 wraps to top
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/bcd_ring_counter_if.sv
// Control/data bundle between the switch/key logic (master) and the BCD
// ring counter (slave).
//   en       step enable, one step per rising edge while high
//   mode     step mode (display_pkg::mode_e encoding)
//   load     synchronous parallel load, wins over en
//   load_val value to load, digit i in bits [4i+3:4i]
//   q        registered BCD value
//   carry    registered one-cycle carry/borrow/limit flag
//   hex      active-low segments, digit i in bits [7i+6:7i]
interface bcd_ring_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [1:0]            mode;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   q;
  logic                  carry;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output en, mode, load, load_val,
    input  q, carry, hex
  );

  modport slave (
    input  en, mode, load, load_val,
    output q, carry, hex
  );
endinterface

// File: rtl/seg7_decode.sv
// 4-bit BCD to active-low seven-segment decoder.
//   bcd_i  digit value; 0..9 decode to numerals, anything else is blank
//   seg_o  segments a..g on bits 0..6, active low
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: a default before the case means every path assigns seg_o,
    // so no latch is inferred.
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_ring_counter.sv
// N-digit BCD counter / digit ring for the seven-segment display labs.
// Counts up or down with decimal ripple, or rotates whole digits, with
// synchronous load and a registered carry/borrow/limit pulse.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset (q=0, carry=0)
//   bus  slave side of bcd_ring_counter_if (en, mode, load, load_val in;
//        q, carry, hex out)
// Parameters: DIGITS (1..8), WRAP_EN (1 = wrap at limits, 0 = saturate).
module bcd_ring_counter
  import display_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  bcd_ring_counter_if.slave   bus
);

  typedef logic [DIGITS-1:0][3:0] digits_t;

  digits_t q_q, q_d;
  logic    carry_q, carry_d;

  // Decimal count result and the ripple out of the top digit, which is
  // exactly the "at the limit" condition (all 9s up, all 0s down).
  digits_t    stepped;
  logic       ripple;
  logic [4:0] step_r;

  // One digit of decimal increment/decrement: {carry_out, new_digit}.
  function automatic logic [4:0] digit_step(input logic [3:0] d, input logic down);
    if (!down) return (d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
    else       return (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
  endfunction

  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    stepped = q_q;
    ripple  = 1'b1;
    step_r  = '0;

    // Ripple chain: a digit steps only when every lower digit wrapped.
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        step_r     = digit_step(q_q[i], bus.mode == MODE_DN);
        stepped[i] = step_r[3:0];
        ripple     = step_r[4];
      end
    end

    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++)
        q_d[i] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
    end else if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_UP, MODE_DN: begin
          carry_d = ripple;
          // In saturate mode a limit event leaves q untouched.
          if (!ripple || WRAP_EN) q_d = stepped;
        end
        MODE_ROL: for (int i = 0; i < DIGITS; i++) q_d[(i + 1) % DIGITS] = q_q[i];
        MODE_ROR: for (int i = 0; i < DIGITS; i++) q_d[i] = q_q[(i + 1) % DIGITS];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  logic [DIGITS-1:0][6:0] hex_w;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decode u_dec (
      .bcd_i (q_q[g]),
      .seg_o (hex_w[g])
    );
  end

  assign bus.q     = q_q;
  assign bus.carry = carry_q;
  assign bus.hex   = hex_w;

endmodule
